// File: rtl/conv_symbol_collector.sv
// conv_symbol_collector
// Receive-side collector for the 3-stream convolutional encoder output.
// Each stream dk is packed LSB-first into bytes. All three bytes go to the
// data FIFOs together under one strobe. One metadata byte per block records
// the block size and whether the block completed (err=0) or was cut short by
// a new start symbol (err=1).
//
// Ports:
//   clk, reset             clock (rising edge), async active-high reset
//   enc_valid              dOut carries a symbol this cycle
//   enc_start              with enc_valid: first symbol of a block
//   enc_size               block size, sampled with enc_start (0 small, 1 large)
//   dOut[2:0]              coded symbol, bit k belongs to stream dk
//   out_full               any output FIFO full
//   ready                  symbol accepted this cycle (combinational)
//   out_data0..2           packed bytes for streams d0..d2
//   wrreq_out              one-cycle write strobe for the three data FIFOs
//   out_meta               {6'b0, err, size}
//   wrreq_meta             one-cycle write strobe for the meta FIFO
//   busy                   a block is open
//   overflow               sticky: a symbol arrived while ready was low
module conv_symbol_collector #(
  parameter int LEN_SMALL = 1056,
  parameter int LEN_LARGE = 6144,
  parameter int CNT_W     = 13
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_valid,
  input  logic       enc_start,
  input  logic       enc_size,
  input  logic [2:0] dOut,
  input  logic       out_full,
  output logic       ready,
  output logic [7:0] out_data0,
  output logic [7:0] out_data1,
  output logic [7:0] out_data2,
  output logic       wrreq_out,
  output logic [7:0] out_meta,
  output logic       wrreq_meta,
  output logic       busy,
  output logic       overflow
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [CNT_W-1:0] LEN_S = CNT_W'(LEN_SMALL);
  localparam logic [CNT_W-1:0] LEN_L = CNT_W'(LEN_LARGE);

  logic [0:0]       state_q, state_d;
  logic             size_q, size_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0][7:0]  shreg_q, shreg_d;
  logic [2:0][7:0]  data_q, data_d;
  logic             wr_out_q, wr_out_d;
  logic [7:0]       meta_q, meta_d;
  logic             wr_meta_q, wr_meta_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] len_cur;
  logic [2:0][7:0]  shreg_ins;

  // ready is forced low during reset so nothing is accepted while the
  // collector is being cleared.
  assign ready   = !out_full && !reset;
  assign accept  = enc_valid && ready;
  assign cnt_inc = cnt_q + 1'b1;
  assign len_cur = size_q ? LEN_L : LEN_S;

  // Current shift registers with this cycle's symbol dropped into the bit
  // slot selected by the low counter bits. When that completes a byte, this
  // is also the value written out.
  always_comb begin
    shreg_ins = shreg_q;
    for (int k = 0; k < 3; k++)
      shreg_ins[k][cnt_q[2:0]] = dOut[k];
  end

  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    meta_d    = meta_q;
    wr_out_d  = 1'b0;
    wr_meta_d = 1'b0;
    ovf_d     = ovf_q || (enc_valid && !ready);

    if (accept) begin
      if (enc_start) begin
        // A start inside an open block closes the old block as errored.
        // Its partial byte is simply overwritten.
        if (state_q == ST_COLLECT) begin
          wr_meta_d = 1'b1;
          meta_d    = {6'b0, 1'b1, size_q};
        end
        state_d = ST_COLLECT;
        size_d  = enc_size;
        cnt_d   = CNT_W'(1);
        for (int k = 0; k < 3; k++)
          shreg_d[k] = {7'b0, dOut[k]};
      end else if (state_q == ST_COLLECT) begin
        shreg_d = shreg_ins;
        cnt_d   = cnt_inc;
        if (cnt_inc[2:0] == 3'd0) begin
          wr_out_d = 1'b1;
          data_d   = shreg_ins;
        end
        // Both lengths are multiples of 8, so block end always coincides
        // with a byte write.
        if (cnt_inc == len_cur) begin
          wr_meta_d = 1'b1;
          meta_d    = {6'b0, 1'b0, size_q};
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      size_q    <= 1'b0;
      cnt_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      wr_out_q  <= 1'b0;
      meta_q    <= '0;
      wr_meta_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      wr_out_q  <= wr_out_d;
      meta_q    <= meta_d;
      wr_meta_q <= wr_meta_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_data0  = data_q[0];
  assign out_data1  = data_q[1];
  assign out_data2  = data_q[2];
  assign wrreq_out  = wr_out_q;
  assign out_meta   = meta_q;
  assign wrreq_meta = wr_meta_q;
  assign busy       = (state_q == ST_COLLECT);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_conv_symbol_collector.sv
module tb_conv_symbol_collector;

  localparam int LS = 1056;
  localparam int LL = 6144;

  logic       clk = 1'b0;
  logic       reset;
  logic       enc_valid, enc_start, enc_size;
  logic [2:0] dOut;
  logic       out_full;
  logic       ready;
  logic [7:0] out_data0, out_data1, out_data2;
  logic       wrreq_out;
  logic [7:0] out_meta;
  logic       wrreq_meta;
  logic       busy;
  logic       overflow;

  conv_symbol_collector #(.LEN_SMALL(LS), .LEN_LARGE(LL), .CNT_W(13)) dut (
    .clk(clk), .reset(reset), .enc_valid(enc_valid), .enc_start(enc_start),
    .enc_size(enc_size), .dOut(dOut), .out_full(out_full), .ready(ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2),
    .wrreq_out(wrreq_out), .out_meta(out_meta), .wrreq_meta(wrreq_meta),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_wr   = 0;

  // Behavioural model: the open block is just the list of its symbols.
  logic [2:0] symq[$];
  logic       m_open, m_size;
  logic [7:0] e_d0, e_d1, e_d2, e_meta;
  logic       e_wr, e_mwr, e_ov;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    symq.delete();
    m_open = 0; m_size = 0;
    e_d0 = 0; e_d1 = 0; e_d2 = 0; e_meta = 0;
    e_wr = 0; e_mwr = 0; e_ov = 0;
  endtask

  task automatic model_step(input logic v, input logic s, input logic sz,
                            input logic [2:0] d, input logic full);
    int n;
    e_wr = 0; e_mwr = 0;
    if (v && full) e_ov = 1;
    if (v && !full) begin
      if (s) begin
        if (m_open) begin e_mwr = 1; e_meta = {6'b0, 1'b1, m_size}; end
        m_open = 1; m_size = sz; symq.delete();
      end
      if (m_open) begin
        symq.push_back(d);
        n = symq.size();
        if (n % 8 == 0) begin
          for (int i = 0; i < 8; i++) begin
            e_d0[i] = symq[n-8+i][0];
            e_d1[i] = symq[n-8+i][1];
            e_d2[i] = symq[n-8+i][2];
          end
          e_wr = 1;
        end
        if (n == (m_size ? LL : LS)) begin
          e_mwr = 1; e_meta = {6'b0, 1'b0, m_size}; m_open = 0;
        end
      end
    end
  endtask

  task automatic check_cycle();
    chk("ready", ready, !out_full);
    chk("wrreq_out", wrreq_out, e_wr);
    chk("wrreq_meta", wrreq_meta, e_mwr);
    chk("busy", busy, m_open);
    chk("overflow", overflow, e_ov);
    chk("out_data0", out_data0, e_d0);
    chk("out_data1", out_data1, e_d1);
    chk("out_data2", out_data2, e_d2);
    chk("out_meta", out_meta, e_meta);
    if (wrreq_out) n_wr++;
  endtask

  task automatic tick(input logic v, input logic s, input logic sz,
                      input logic [2:0] d, input logic full);
    enc_valid = v; enc_start = s; enc_size = sz; dOut = d; out_full = full;
    @(posedge clk);
    model_step(v, s, sz, d, full);
    #1;
    check_cycle();
  endtask

  // Asserts reset between edges, checks the outputs clear without a clock,
  // holds reset over one edge, then releases it.
  task automatic do_reset();
    enc_valid = 0; enc_start = 0; enc_size = 0; dOut = 0; out_full = 0;
    #2 reset = 1;
    #1;
    chk("rst ready", ready, 0);
    chk("rst data", {out_data0, out_data1, out_data2}, 0);
    chk("rst meta", out_meta, 0);
    chk("rst strobes", {wrreq_out, wrreq_meta}, 0);
    chk("rst busy", busy, 0);
    chk("rst overflow", overflow, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1 chk("ready after rst", ready, 1);
  endtask

  task automatic run_block(input logic sz, input int nsym);
    tick(1, 1, sz, 3'($urandom), 0);
    for (int i = 1; i < nsym; i++) tick(1, 0, sz, 3'($urandom), 0);
  endtask

  logic [7:0] seq;

  initial begin
    reset = 1; enc_valid = 0; enc_start = 0; enc_size = 0; dOut = 0; out_full = 0;
    model_reset();
    #3;
    do_reset();

    // Small block of constant 3'b101.
    n_wr = 0;
    tick(1, 1, 0, 3'b101, 0);
    for (int i = 1; i < LS; i++) tick(1, 0, 0, 3'b101, 0);
    chk("small n_wr", n_wr, 132);
    chk("small last wr", wrreq_out, 1);
    chk("small meta wr", wrreq_meta, 1);
    chk("small meta", out_meta, 8'h00);
    chk("small d0", out_data0, 8'hFF);
    chk("small d1", out_data1, 8'h00);
    chk("small d2", out_data2, 8'hFF);
    chk("small busy", busy, 0);

    // Bit order on stream d0.
    seq = 8'b1000_1101; // symbol i carries seq[i]: 1,0,1,1,0,0,0,1
    for (int i = 0; i < 8; i++)
      tick(1, (i == 0), 0, {2'($urandom), seq[i]}, 0);
    chk("order wr", wrreq_out, 1);
    chk("order d0", out_data0, 8'h8D);
    for (int i = 8; i < LS; i++) tick(1, 0, 0, 3'($urandom), 0);

    // Large block.
    n_wr = 0;
    run_block(1, LL);
    chk("large n_wr", n_wr, 768);
    chk("large meta wr", wrreq_meta, 1);
    chk("large meta", out_meta, 8'h01);
    chk("large busy", busy, 0);
    tick(0, 0, 0, 0, 0);

    // Abort after 20 symbols, then a full small block.
    n_wr = 0;
    run_block(0, 20);
    tick(1, 1, 0, 3'($urandom), 0);
    chk("abort n_wr", n_wr, 2);
    chk("abort meta wr", wrreq_meta, 1);
    chk("abort meta", out_meta, 8'h02);
    chk("abort busy", busy, 1);
    n_wr = 0;
    for (int i = 1; i < LS; i++) tick(1, 0, 0, 3'($urandom), 0);
    chk("post-abort n_wr", n_wr, 132);
    chk("post-abort meta", out_meta, 8'h00);

    // Backpressure mid-block.
    run_block(0, 4);
    n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 3'($urandom), 1);
      chk("bp ready", ready, 0);
    end
    chk("bp no wr", n_wr, 0);
    chk("bp overflow", overflow, 1);
    for (int i = 4; i < LS; i++) tick(1, 0, 0, 3'($urandom), 0);
    chk("bp meta", out_meta, 8'h00);
    chk("overflow sticky", overflow, 1);

    // Reset after 100 symbols, then a clean block.
    run_block(0, 100);
    do_reset();
    chk("rst no meta", wrreq_meta, 0);
    n_wr = 0;
    run_block(0, LS);
    chk("after rst n_wr", n_wr, 132);
    chk("after rst meta wr", wrreq_meta, 1);
    chk("after rst meta", out_meta, 8'h00);

    // Random traffic.
    for (int i = 0; i < 6000; i++)
      tick($urandom_range(0, 9) < 8, $urandom_range(0, 1999) == 0,
           $urandom_range(0, 7) == 0, 3'($urandom), $urandom_range(0, 19) == 0);
    // Make sure random traffic exercised a start path too.
    run_block(0, LS);
    chk("final meta", out_meta, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
